// File: rtl/dvi_timing_probe.sv
// dvi_timing_probe: measures line/frame timing, sync polarity, lock and a single
// pixel of a DE/HS/VS/RGB stream. Define TIMING_PROBE_CRC_EN to add a per-frame CRC-16.
module dvi_timing_probe #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 3
) (
  input  logic             clk_40m_tree,
  input  logic             reset_loc,
  input  logic             vid_de,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic [23:0]      vid_rgb,
  input  logic [CNT_W-1:0] probe_x,
  input  logic [CNT_W-1:0] probe_y,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             locked,
  output logic             frame_tick,
  output logic [23:0]      probe_rgb,
  output logic             probe_valid,
`ifdef TIMING_PROBE_CRC_EN
  output logic [15:0]      frame_crc,
`endif
  output logic [1:0]       fsm_state
);

  localparam logic [CNT_W-1:0] CMAX     = '1;
  localparam int               TO_W     = 2 * CNT_W;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEAS   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             de_r, hs_r, vs_r;
  logic [23:0]      rgb_r;
  logic             pol_seen;
  logic             hs_n, vs_n, hs_n_d, vs_n_d;
  logic             hs_edge, vs_edge;
  logic [CNT_W-1:0] pix_cnt, run_cnt, lines, de_lines;
  logic [CNT_W-1:0] ht_new, ha_new, lines_inc, de_lines_inc;
  logic [CNT_W-1:0] px_x, px_y;
  logic             line_had_de;
  logic [CNT_W-1:0] prev_ht, prev_ha, prev_vt, prev_va;
  logic             prev_valid;
  logic [3:0]       match_cnt, cnt_nxt;
  logic             sat_any, same;
  logic [TO_W-1:0]  to_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  assign fsm_state = state;

  // Input register stage; every latency below counts from here.
  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      de_r  <= 1'b0;
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      rgb_r <= '0;
    end else begin
      de_r  <= vid_de;
      hs_r  <= vid_hs;
      vs_r  <= vid_vs;
      rgb_r <= vid_rgb;
    end
  end

  // Sync is inactive while DE is high, so DE cycles reveal the idle sync level.
  // Edges are ignored until the first DE cycle so an active-low sync does not
  // look like a leading edge straight out of reset.
  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      hs_pol   <= 1'b1;
      vs_pol   <= 1'b1;
      pol_seen <= 1'b0;
      hs_n_d   <= 1'b0;
      vs_n_d   <= 1'b0;
    end else begin
      if (de_r) begin
        hs_pol   <= ~hs_r;
        vs_pol   <= ~vs_r;
        pol_seen <= 1'b1;
      end
      hs_n_d <= hs_n;
      vs_n_d <= vs_n;
    end
  end

  assign hs_n    = ~(hs_r ^ hs_pol);
  assign vs_n    = ~(vs_r ^ vs_pol);
  assign hs_edge = pol_seen & hs_n & ~hs_n_d;
  assign vs_edge = pol_seen & vs_n & ~vs_n_d;

  // Values as they stand once the current HS edge (if any) has been applied.
  assign line_had_de  = (run_cnt != '0);
  assign ht_new       = hs_edge ? sat_inc(pix_cnt) : h_total;
  assign ha_new       = (hs_edge && line_had_de) ? run_cnt : h_active;
  assign lines_inc    = hs_edge ? sat_inc(lines) : lines;
  assign de_lines_inc = (hs_edge && line_had_de) ? sat_inc(de_lines) : de_lines;

  // Pixel coordinate of the current DE cycle within the active area.
  assign px_x = hs_edge ? '0 : run_cnt;
  assign px_y = vs_edge ? '0 : de_lines_inc;

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      pix_cnt  <= '0;
      run_cnt  <= '0;
      lines    <= '0;
      de_lines <= '0;
      h_total  <= '0;
      h_active <= '0;
    end else begin
      pix_cnt  <= hs_edge ? '0 : sat_inc(pix_cnt);
      if (hs_edge)
        run_cnt <= de_r ? CNT_W'(1) : '0;
      else if (de_r)
        run_cnt <= sat_inc(run_cnt);
      h_total  <= ht_new;
      h_active <= ha_new;
      lines    <= vs_edge ? '0 : lines_inc;
      de_lines <= vs_edge ? '0 : de_lines_inc;
    end
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= 1'b0;
      if (de_r && px_x == probe_x && px_y == probe_y) begin
        probe_rgb   <= rgb_r;
        probe_valid <= 1'b1;
      end
    end
  end

  // A saturated measurement is never trusted as a match.
  assign sat_any = (ht_new == CMAX) || (ha_new == CMAX) ||
                   (lines_inc == CMAX) || (de_lines_inc == CMAX);
  assign same    = prev_valid && !sat_any &&
                   ({ht_new, ha_new, lines_inc, de_lines_inc} ==
                    {prev_ht, prev_ha, prev_vt, prev_va});
  assign cnt_nxt = !same ? 4'd0 : (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (vs_edge) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (vs_edge && cnt_nxt >= LOCK_TGT) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (vs_edge) begin
          if (!same) state_nxt = S_MEAS;
        end else if (to_cnt == '1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      frame_tick <= 1'b0;
      locked     <= 1'b0;
      v_total    <= '0;
      v_active   <= '0;
      match_cnt  <= '0;
      prev_valid <= 1'b0;
      prev_ht    <= '0;
      prev_ha    <= '0;
      prev_vt    <= '0;
      prev_va    <= '0;
      to_cnt     <= '0;
    end else begin
      frame_tick <= 1'b0;
      if (vs_edge) begin
        if (state == S_IDLE) begin
          // The partial frame seen before the first VS edge is discarded.
          match_cnt  <= '0;
          prev_valid <= 1'b0;
        end else begin
          frame_tick <= 1'b1;
          v_total    <= lines_inc;
          v_active   <= de_lines_inc;
          match_cnt  <= cnt_nxt;
          prev_ht    <= ht_new;
          prev_ha    <= ha_new;
          prev_vt    <= lines_inc;
          prev_va    <= de_lines_inc;
          prev_valid <= 1'b1;
        end
      end
      if (state != S_LOCKED || vs_edge) to_cnt <= '0;
      else                              to_cnt <= to_cnt + TO_W'(1);
      locked <= (state_nxt == S_LOCKED);
    end
  end

`ifdef TIMING_PROBE_CRC_EN
  logic [15:0] crc_run;

  // CRC-16-CCITT, MSB first, all 24 RGB bits of one pixel per clock.
  function automatic logic [15:0] crc24(input logic [15:0] c_in, input logic [23:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 23; i >= 0; i--)
      c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  always_ff @(posedge clk_40m_tree or posedge reset_loc) begin
    if (reset_loc) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_edge) begin
      if (state != S_IDLE) frame_crc <= crc_run;
      crc_run <= de_r ? crc24(16'hFFFF, rgb_r) : 16'hFFFF;
    end else if (de_r) begin
      crc_run <= crc24(crc_run, rgb_r);
    end
  end
`endif

endmodule

// File: tb/tb_dvi_timing_probe.sv
// tb_dvi_timing_probe: drives a scaled-down raster (24x12 total, 16x8 active) into
// dvi_timing_probe and checks measurements, lock, probe, reset and timeout.
module tb_dvi_timing_probe;
  localparam int CNT_W = 5;
  localparam int HA = 16, HS0 = 18, HSL = 3;
  localparam int VA = 8, VT = 12, VS0 = 9, VSL = 2;

  // clock / reset
  logic clk_40m_tree = 1'b0;
  logic reset_loc    = 1'b1;
  always #5 clk_40m_tree = ~clk_40m_tree;

  logic             vid_de = 1'b0, vid_hs = 1'b0, vid_vs = 1'b0;
  logic [23:0]      vid_rgb = '0;
  logic [CNT_W-1:0] probe_x = '0, probe_y = '0;
  logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
  logic             hs_pol, vs_pol, locked, frame_tick, probe_valid;
  logic [23:0]      probe_rgb;
  logic [1:0]       fsm_state;
`ifdef TIMING_PROBE_CRC_EN
  logic [15:0]      frame_crc;
`endif

  dvi_timing_probe #(.CNT_W(CNT_W), .LOCK_FRAMES(3)) dut (
    .clk_40m_tree(clk_40m_tree), .reset_loc(reset_loc),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
    .probe_x(probe_x), .probe_y(probe_y),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked), .frame_tick(frame_tick),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid),
`ifdef TIMING_PROBE_CRC_EN
    .frame_crc(frame_crc),
`endif
    .fsm_state(fsm_state)
  );

  // monitor: snapshots at every frame_tick
  int               tick_cnt = 0, pv_cnt = 0;
  logic [CNT_W-1:0] t_ht, t_ha, t_vt, t_va;
  logic             t_locked;
  logic             lock_log [0:255];
  int               vs_log [0:255];
  int               vs_driven = 0;
`ifdef TIMING_PROBE_CRC_EN
  logic [15:0]      t_crc;
`endif

  always @(negedge clk_40m_tree) begin
    if (frame_tick) begin
      tick_cnt           <= tick_cnt + 1;
      t_ht               <= h_total;
      t_ha               <= h_active;
      t_vt               <= v_total;
      t_va               <= v_active;
      t_locked           <= locked;
      lock_log[tick_cnt] <= locked;
      vs_log[tick_cnt]   <= vs_driven;
`ifdef TIMING_PROBE_CRC_EN
      t_crc              <= frame_crc;
`endif
    end
    if (probe_valid) pv_cnt <= pv_cnt + 1;
  end

  // scoreboard counters
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  bit vs_prev_act = 1'b0;
  bit zero_px     = 1'b0;

  task automatic drive_px(input int ht, input int v, input int h, input bit inv, input bit vs_on);
    bit de, hs, vs;
    int pos;
    de  = (v < VA) && (h < HA);
    hs  = (h >= HS0) && (h < HS0 + HSL);
    pos = v * ht + h;
    vs  = vs_on && (pos >= VS0 * ht + HS0) && (pos < (VS0 + VSL) * ht + HS0);
    @(negedge clk_40m_tree);
    if (vs && !vs_prev_act) vs_driven++;
    vs_prev_act = vs;
    vid_de  = de;
    vid_hs  = hs ^ inv;
    vid_vs  = vs ^ inv;
    vid_rgb = (de && !zero_px) ? {8'(v), 8'(h), 8'hA5} : 24'h0;
  endtask

  task automatic run_lines(input int ht, input bit inv, input bit vs_on, input int v0, input int v1);
    for (int v = v0; v < v1; v++)
      for (int h = 0; h < ht; h++)
        drive_px(ht, v, h, inv, vs_on);
    #1;
  endtask

  task automatic run_frames(input int n, input int ht, input bit inv, input bit vs_on);
    for (int f = 0; f < n; f++) run_lines(ht, inv, vs_on, 0, VT);
  endtask

  task automatic do_reset(input bit inv);
    @(negedge clk_40m_tree);
    reset_loc   = 1'b1;
    vid_de      = 1'b0;
    vid_hs      = inv;
    vid_vs      = inv;
    vid_rgb     = '0;
    vs_prev_act = 1'b0;
    repeat (3) @(negedge clk_40m_tree);
    reset_loc = 1'b0;
  endtask

  function automatic logic [15:0] ref_crc_zero(input int npx);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < npx * 24; i++)
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  typedef struct {
    int          ht;
    bit          inv;
    int          px, py, nfr;
    int          e_ht, e_ha, e_vt, e_va;
    bit          e_pol;
    int          e_ticks, e_lock;
    bit          e_locked;
    logic [23:0] e_rgb;
    int          e_pv;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base_t, base_pv, base_vs, lk;

    //          ht  inv px py nfr  ht  ha  vt va pol tk lk lkd rgb          pv
    vecs[0] = '{24, 0,  5, 2, 5,   24, 16, 12, 8, 1, 4, 3, 1, 24'h0205A5, 5};
    vecs[1] = '{24, 1,  5, 2, 5,   24, 16, 12, 8, 0, 4, 3, 1, 24'h0205A5, 5};
    vecs[2] = '{40, 0,  5, 2, 5,   31, 16, 12, 8, 1, 4, 0, 0, 24'h0205A5, 5};
    vecs[3] = '{24, 0, 15, 7, 4,   24, 16, 12, 8, 1, 3, 3, 1, 24'h070FA5, 4};
    vecs[4] = '{24, 0, 16, 0, 4,   24, 16, 12, 8, 1, 3, 3, 1, 24'h000000, 0};

    // reset state
    repeat (3) @(negedge clk_40m_tree);
    check("rst_h_total", 32'(h_total), 0);
    check("rst_v_total", 32'(v_total), 0);
    check("rst_pols", {hs_pol, vs_pol}, 2'b11);
    check("rst_locked", 32'(locked), 0);
    check("rst_fsm", 32'(fsm_state), 0);

    // table-driven scenarios
    for (int i = 0; i < 5; i++) begin
      probe_x = CNT_W'(vecs[i].px);
      probe_y = CNT_W'(vecs[i].py);
      do_reset(vecs[i].inv);
      base_t  = tick_cnt;
      base_pv = pv_cnt;
      run_frames(vecs[i].nfr, vecs[i].ht, vecs[i].inv, 1'b1);
      lk = 0;
      for (int k = tick_cnt - 1; k >= base_t; k--) if (lock_log[k]) lk = k - base_t + 1;
      check($sformatf("v%0d_h_total", i), 32'(t_ht), vecs[i].e_ht);
      check($sformatf("v%0d_h_active", i), 32'(t_ha), vecs[i].e_ha);
      check($sformatf("v%0d_v_total", i), 32'(t_vt), vecs[i].e_vt);
      check($sformatf("v%0d_v_active", i), 32'(t_va), vecs[i].e_va);
      check($sformatf("v%0d_hs_pol", i), 32'(hs_pol), 32'(vecs[i].e_pol));
      check($sformatf("v%0d_vs_pol", i), 32'(vs_pol), 32'(vecs[i].e_pol));
      check($sformatf("v%0d_ticks", i), tick_cnt - base_t, vecs[i].e_ticks);
      check($sformatf("v%0d_lock_tick", i), lk, vecs[i].e_lock);
      check($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].e_locked));
      check($sformatf("v%0d_probe_rgb", i), 32'(probe_rgb), 32'(vecs[i].e_rgb));
      check($sformatf("v%0d_probe_valid", i), pv_cnt - base_pv, vecs[i].e_pv);
    end

    // lock drop on a disturbed frame, relock after three good frames
    probe_x = CNT_W'(5);
    probe_y = CNT_W'(2);
    do_reset(1'b0);
    run_frames(4, 24, 1'b0, 1'b1);
    check("relock_pre_locked", 32'(locked), 1);
    base_t = tick_cnt;
    run_frames(1, 25, 1'b0, 1'b1);
    check("relock_bad_tick", tick_cnt - base_t, 1);
    check("relock_bad_h_total", 32'(t_ht), 25);
    check("relock_bad_locked", 32'(t_locked), 0);
    for (int g = 1; g <= 3; g++) begin
      run_frames(1, 24, 1'b0, 1'b1);
      check($sformatf("relock_good%0d_locked", g), 32'(t_locked), (g == 3) ? 1 : 0);
    end

    // VS stops while locked: lock held below the timeout, dropped after it
    base_t = tick_cnt;
    run_frames(3, 24, 1'b0, 1'b0);
    check("timeout_early_locked", 32'(locked), 1);
    run_frames(1, 24, 1'b0, 1'b0);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_fsm_idle", 32'(fsm_state), 0);
    check("timeout_no_ticks", tick_cnt - base_t, 0);
    run_frames(2, 24, 1'b0, 1'b1);
    check("timeout_restart_ticks", tick_cnt - base_t, 1);

    // reset pulsed mid-frame on a locked stream
    run_frames(3, 24, 1'b0, 1'b1);
    check("midrst_pre_locked", 32'(locked), 1);
    run_lines(24, 1'b0, 1'b1, 0, 5);
    @(negedge clk_40m_tree);
    reset_loc = 1'b1;
    #1;
    check("midrst_h_total", 32'(h_total), 0);
    check("midrst_h_active", 32'(h_active), 0);
    check("midrst_v_total", 32'(v_total), 0);
    check("midrst_v_active", 32'(v_active), 0);
    check("midrst_pols", {hs_pol, vs_pol}, 2'b11);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_probe_rgb", 32'(probe_rgb), 0);
    check("midrst_fsm", 32'(fsm_state), 0);
    repeat (2) @(negedge clk_40m_tree);
    reset_loc = 1'b0;
    base_t  = tick_cnt;
    base_vs = vs_driven;
    run_lines(24, 1'b0, 1'b1, 5, VT);
    check("midrst_no_tick_first_vs", tick_cnt - base_t, 0);
    run_frames(1, 24, 1'b0, 1'b1);
    check("midrst_ticks", tick_cnt - base_t, 1);
    check("midrst_tick_after_vs", vs_log[base_t] - base_vs, 2);

`ifdef TIMING_PROBE_CRC_EN
    zero_px = 1'b1;
    do_reset(1'b0);
    run_frames(2, 24, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      run_frames(1, 24, 1'b0, 1'b1);
      check($sformatf("crc_frame%0d", f), 32'(t_crc), 32'(ref_crc_zero(HA * VA)));
    end
    zero_px = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
